riscv_core_dcache_axi_bridge: RTL and testbench
===============================================

# riscv_core_dcache_axi_bridge

Memory-side responder for the data cache's refill/write-through request interface. It accepts block-refill read requests and single-word write requests from the dcache and turns them into AXI4 master transactions. Reads are 4-beat INCR bursts assembled into one cache block; writes are single-beat with byte strobes. It sits between the dcache top and the SoC AXI interconnect and returns one-cycle done pulses to the cache.

## Interface
- ADDR_WIDTH, 64, address width
- CORE_DATA_WIDTH, 64, write data width from cache
- AXI_DATA_WIDTH, 256, cache block width returned on refill
- BUS_WIDTH, 64, AXI data bus width; BEATS = AXI_DATA_WIDTH/BUS_WIDTH (4)

Ports:
- i_clk  in  1  clock; the single clock for the block
- i_rst_n  in  1  reset; asynchronous, active-low
- i_mem_read_req  in  1  refill request, held until done
- i_mem_read_address  in  ADDR_WIDTH  refill address (any byte within block)
- o_mem_read_done  out  1  one-cycle pulse; o_block_to_cache valid in that cycle
- o_block_to_cache  out  AXI_DATA_WIDTH  assembled block, beat i at [i*64 +: 64]
- i_mem_write_valid  in  1  write request, held until done
- i_mem_write_address  in  ADDR_WIDTH  write address
- i_mem_write_data  in  CORE_DATA_WIDTH  write data, lane-aligned
- i_mem_write_strobe  in  8  byte enables
- o_mem_write_done  out  1  one-cycle pulse on write completion
- o_axi_araddr  out  ADDR_WIDTH  block-aligned read address
- o_axi_arlen  out  8  BEATS-1
- o_axi_arvalid / i_axi_arready  out/in  1  AR handshake
- i_axi_rdata  in  BUS_WIDTH  read beat
- i_axi_rresp  in  2  read response
- i_axi_rlast  in  1  last beat marker
- i_axi_rvalid / o_axi_rready  in/out  1  R handshake
- o_axi_awaddr  out  ADDR_WIDTH  8-byte-aligned write address
- o_axi_awvalid / i_axi_awready  out/in  1  AW handshake
- o_axi_wdata  out  BUS_WIDTH  write data
- o_axi_wstrb  out  8  write strobe
- o_axi_wvalid / i_axi_wready  out/in  1  W handshake
- i_axi_bresp  in  2  write response
- i_axi_bvalid / o_axi_bready  in/out  1  B handshake

The SoC wrapper drives ARSIZE/AWSIZE=3, ARBURST/AWBURST=INCR, AWLEN=0, and WLAST=1 from package constants.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: a pending write has priority over a pending read. Write-through ordering requires that a write is never overtaken.
- IDLE→WR_REQ on i_mem_write_valid. Latch address (low 3 bits cleared), data and strobe. Assert AWVALID and WVALID together; track aw_done and w_done independently. Go to WR_RESP when both have handshaked.
- WR_RESP: BREADY=1. On BVALID→DONE, pulse o_mem_write_done.
- IDLE→RD_ADDR on i_mem_read_req (and no write). Latch the address with the low log2(AXI_DATA_WIDTH/8) bits cleared. ARVALID=1 until ARREADY→RD_DATA.
- RD_DATA: RREADY=1. Each RVALID beat writes block slice [cnt*64 +: 64], then cnt++. Last beat is cnt==BEATS-1 (the counter is authoritative, not RLAST). Then DONE, pulse o_mem_read_done.
- DONE: exactly one cycle. Requests are ignored here, since the cache deasserts its request the cycle after done. Then → IDLE.
- o_block_to_cache holds its value until the next refill starts.
- AXI valids never drop before their handshake. Latched request fields are not re-sampled mid-transaction.
- Reset (any state, including mid-burst): state=IDLE, cnt=0, all valids/readies/done low, block=0, addresses=0. No done is issued for an aborted transaction; the interconnect is reset by the same i_rst_n.

## Timing
- Request is sampled in IDLE at cycle 0. AR/AW/W valid appear at cycle 1 (registered).
- Minimum read latency, zero-wait slave: AR handshake at cycle 1, beats at cycles 2–5, done at cycle 6.
- Minimum write latency: AW+W handshake at cycle 1, B at cycle 2, done at cycle 3.
- Done outputs are registered; o_block_to_cache is stable in the done cycle.
- Back-to-back: the next request is accepted no earlier than the cycle after DONE.

## Configuration
- RISCV_DCACHE_AXI_ERR_EN defined:
  - Adds outputs o_mem_read_err and o_mem_write_err, each valid with the matching done pulse.
  - The error is set if any RRESP or BRESP is nonzero, or if RLAST disagrees with the beat counter.
- Undefined: these ports are absent; responses and RLAST are ignored, and the transaction completes normally.

## Structure
- Package riscv_core_dcache_axi_pkg: state enum, BEATS, the AXI size/burst/len constants, and the RESP_OKAY/SLVERR/DECERR codes.
- One sub-module, riscv_core_dcache_line_assembler: beat counter, slice write enable and last-beat flag. The FSM stays in the bridge.

## Test plan
- Refill at 0x1000_0018, zero-wait slave, beats 0x11..,0x22..,0x33..,0x44.. → ARADDR=0x1000_0000, ARLEN=3, done at cycle 6, block={0x44..,0x33..,0x22..,0x11..}.
- Write addr 0x2004, data 0xDEAD_BEEF_0000_0000, strobe 0xF0 → AWADDR=0x2000, WSTRB=0xF0, done at cycle 3.
- Read and write requested in the same cycle → AW issued first; ARVALID only after the write's done+DONE cycle; both dones pulse exactly once.
- Slave delays: AWREADY 3 cycles after WREADY, RVALID gaps of 2 cycles between beats → valids held stable, block correct, single done pulse each.
- Reset asserted after beat 2 of 4 → all outputs 0 immediately. A fresh refill after release completes normally with no stale slices.
- With RISCV_DCACHE_AXI_ERR_EN: BRESP=SLVERR → o_mem_write_err=1 with done. RLAST on beat 1 → o_mem_read_err=1 at completion.

Source files
------------

// File: rtl/riscv_core_dcache_axi_pkg.sv
// Shared types and AXI constants for the dcache-to-AXI refill/write-through bridge.
package riscv_core_dcache_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int BEATS = 4;

  // Fixed AXI attributes driven by the SoC wrapper.
  localparam logic [2:0] AXI_SIZE       = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_ARLEN      = 8'(BEATS - 1);
  localparam logic [7:0] AXI_AWLEN      = 8'd0;
  localparam logic       AXI_WLAST      = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/riscv_core_dcache_line_assembler.sv
// Beat counter for refill bursts: one-hot slice write enable and last-beat flag.
module riscv_core_dcache_line_assembler
  import riscv_core_dcache_axi_pkg::*;
#(
  parameter int NBEATS = BEATS
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_beat,
  output logic [NBEATS-1:0] o_slice_we,
  output logic              o_last
);

  localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NBEATS - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_beat) begin
      r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_last = (r_cnt == LAST_CNT);

  always_comb begin
    o_slice_we = '0;
    for (int i = 0; i < NBEATS; i++) begin
      o_slice_we[i] = i_beat && (r_cnt == CW'(i));
    end
  end

endmodule

// File: rtl/riscv_core_dcache_axi_bridge.sv
// Turns dcache block refills and write-through words into AXI4 bursts/single beats.
// Optional RISCV_DCACHE_AXI_ERR_EN adds o_mem_read_err/o_mem_write_err status outputs.
module riscv_core_dcache_axi_bridge
  import riscv_core_dcache_axi_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int CORE_DATA_WIDTH = 64,
  parameter int AXI_DATA_WIDTH  = 256,
  parameter int BUS_WIDTH       = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mem_read_req,
  input  logic [ADDR_WIDTH-1:0]     i_mem_read_address,
  output logic                      o_mem_read_done,
  output logic [AXI_DATA_WIDTH-1:0] o_block_to_cache,
  input  logic                      i_mem_write_valid,
  input  logic [ADDR_WIDTH-1:0]     i_mem_write_address,
  input  logic [CORE_DATA_WIDTH-1:0] i_mem_write_data,
  input  logic [7:0]                i_mem_write_strobe,
  output logic                      o_mem_write_done,
`ifdef RISCV_DCACHE_AXI_ERR_EN
  output logic                      o_mem_read_err,
  output logic                      o_mem_write_err,
`endif
  output logic [ADDR_WIDTH-1:0]     o_axi_araddr,
  output logic [7:0]                o_axi_arlen,
  output logic                      o_axi_arvalid,
  input  logic                      i_axi_arready,
  input  logic [BUS_WIDTH-1:0]      i_axi_rdata,
  input  logic [1:0]                i_axi_rresp,
  input  logic                      i_axi_rlast,
  input  logic                      i_axi_rvalid,
  output logic                      o_axi_rready,
  output logic [ADDR_WIDTH-1:0]     o_axi_awaddr,
  output logic                      o_axi_awvalid,
  input  logic                      i_axi_awready,
  output logic [BUS_WIDTH-1:0]      o_axi_wdata,
  output logic [7:0]                o_axi_wstrb,
  output logic                      o_axi_wvalid,
  input  logic                      i_axi_wready,
  input  logic [1:0]                i_axi_bresp,
  input  logic                      i_axi_bvalid,
  output logic                      o_axi_bready
);

  localparam int NBEATS = AXI_DATA_WIDTH / BUS_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ADDR_WIDTH'(AXI_DATA_WIDTH / 8 - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ADDR_WIDTH'(BUS_WIDTH / 8 - 1);

  state_e                    r_state, w_state_d;
  logic [ADDR_WIDTH-1:0]     r_araddr, r_awaddr;
  logic [BUS_WIDTH-1:0]      r_wdata;
  logic [7:0]                r_wstrb;
  logic                      r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic                      r_aw_done, r_w_done;
  logic                      r_read_done, r_write_done;
  logic [AXI_DATA_WIDTH-1:0] r_block;

  logic w_arvalid_d, w_rready_d, w_awvalid_d, w_wvalid_d, w_bready_d;
  logic w_read_done_d, w_write_done_d, w_latch_rd, w_latch_wr;
  logic w_ar_hs, w_aw_hs, w_w_hs, w_b_hs, w_beat, w_last;
  logic [NBEATS-1:0] w_slice_we;

  assign w_ar_hs = r_arvalid && i_axi_arready;
  assign w_aw_hs = r_awvalid && i_axi_awready;
  assign w_w_hs  = r_wvalid  && i_axi_wready;
  assign w_b_hs  = r_bready  && i_axi_bvalid;
  assign w_beat  = r_rready  && i_axi_rvalid;

  riscv_core_dcache_line_assembler #(.NBEATS(NBEATS)) u_line_assembler (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (w_latch_rd),
    .i_beat     (w_beat),
    .o_slice_we (w_slice_we),
    .o_last     (w_last)
  );

  // Next-state and next-output logic; every channel output is registered from these.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_d      = r_state;
    w_arvalid_d    = r_arvalid;
    w_awvalid_d    = r_awvalid;
    w_wvalid_d     = r_wvalid;
    w_rready_d     = 1'b0;
    w_bready_d     = 1'b0;
    w_read_done_d  = 1'b0;
    w_write_done_d = 1'b0;
    w_latch_rd     = 1'b0;
    w_latch_wr     = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Writes win so a write-through is never overtaken by a later refill.
        if (i_mem_write_valid) begin
          w_state_d   = WR_REQ;
          w_awvalid_d = 1'b1;
          w_wvalid_d  = 1'b1;
          w_latch_wr  = 1'b1;
        end else if (i_mem_read_req) begin
          w_state_d   = RD_ADDR;
          w_arvalid_d = 1'b1;
          w_latch_rd  = 1'b1;
        end
      end
      WR_REQ: begin
        if (w_aw_hs) w_awvalid_d = 1'b0;
        if (w_w_hs)  w_wvalid_d  = 1'b0;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_d  = WR_RESP;
          w_bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (w_b_hs) begin
          w_state_d      = DONE;
          w_write_done_d = 1'b1;
        end else begin
          w_bready_d = 1'b1;
        end
      end
      RD_ADDR: begin
        if (w_ar_hs) begin
          w_state_d   = RD_DATA;
          w_arvalid_d = 1'b0;
          w_rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (w_beat && w_last) begin
          w_state_d     = DONE;
          w_read_done_d = 1'b1;
        end else begin
          w_rready_d = 1'b1;
        end
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_read_done  <= 1'b0;
      r_write_done <= 1'b0;
      r_araddr     <= '0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      r_state      <= w_state_d;
      r_arvalid    <= w_arvalid_d;
      r_rready     <= w_rready_d;
      r_awvalid    <= w_awvalid_d;
      r_wvalid     <= w_wvalid_d;
      r_bready     <= w_bready_d;
      r_read_done  <= w_read_done_d;
      r_write_done <= w_write_done_d;
      if (w_latch_rd) r_araddr <= i_mem_read_address & ~BLOCK_MASK;
      if (w_latch_wr) begin
        r_awaddr  <= i_mem_write_address & ~WORD_MASK;
        r_wdata   <= BUS_WIDTH'(i_mem_write_data);
        r_wstrb   <= i_mem_write_strobe;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

  // NOTE: the block register is wide but still reset, so an aborted refill never exposes partial data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_block <= '0;
    end else begin
      for (int i = 0; i < NBEATS; i++) begin
        if (w_slice_we[i]) r_block[i*BUS_WIDTH +: BUS_WIDTH] <= i_axi_rdata;
      end
    end
  end

`ifdef RISCV_DCACHE_AXI_ERR_EN
  logic r_rd_err_acc, r_read_err, r_write_err;
  logic w_beat_err;

  // The beat counter decides completion; RLAST is only cross-checked against it.
  assign w_beat_err = w_beat && (resp_is_err(i_axi_rresp) || (i_axi_rlast != w_last));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_err_acc <= 1'b0;
      r_read_err   <= 1'b0;
      r_write_err  <= 1'b0;
    end else begin
      if (w_latch_rd)      r_rd_err_acc <= 1'b0;
      else if (w_beat_err) r_rd_err_acc <= 1'b1;
      r_read_err  <= w_read_done_d && (r_rd_err_acc || w_beat_err);
      r_write_err <= w_write_done_d && resp_is_err(i_axi_bresp);
    end
  end

  assign o_mem_read_err  = r_read_err;
  assign o_mem_write_err = r_write_err;
`else
  logic w_unused;
  assign w_unused = ^{i_axi_rresp, i_axi_rlast, i_axi_bresp};
`endif

  assign o_mem_read_done  = r_read_done;
  assign o_mem_write_done = r_write_done;
  assign o_block_to_cache = r_block;
  assign o_axi_araddr     = r_araddr;
  assign o_axi_arlen      = 8'(NBEATS - 1);
  assign o_axi_arvalid    = r_arvalid;
  assign o_axi_rready     = r_rready;
  assign o_axi_awaddr     = r_awaddr;
  assign o_axi_awvalid    = r_awvalid;
  assign o_axi_wdata      = r_wdata;
  assign o_axi_wstrb      = r_wstrb;
  assign o_axi_wvalid     = r_wvalid;
  assign o_axi_bready     = r_bready;

endmodule

// File: tb/tb_riscv_core_dcache_axi_bridge.sv
// Directed bench for the dcache AXI bridge: vector table plus multi-cycle corner sequences.
module tb_riscv_core_dcache_axi_bridge;
  import riscv_core_dcache_axi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         rd_req, wr_valid;
  logic [63:0]  rd_addr, wr_addr, wr_data;
  logic [7:0]   wr_strb;
  logic         rd_done, wr_done;
  logic [255:0] block;
  logic [63:0]  araddr, awaddr, wdata;
  logic [7:0]   arlen, wstrb;
  logic         arvalid, arready, rready, rvalid, rlast;
  logic [63:0]  rdata;
  logic [1:0]   rresp, bresp;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
`ifdef RISCV_DCACHE_AXI_ERR_EN
  logic         rd_err, wr_err;
`endif

  riscv_core_dcache_axi_bridge dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_mem_read_req      (rd_req),
    .i_mem_read_address  (rd_addr),
    .o_mem_read_done     (rd_done),
    .o_block_to_cache    (block),
    .i_mem_write_valid   (wr_valid),
    .i_mem_write_address (wr_addr),
    .i_mem_write_data    (wr_data),
    .i_mem_write_strobe  (wr_strb),
    .o_mem_write_done    (wr_done),
`ifdef RISCV_DCACHE_AXI_ERR_EN
    .o_mem_read_err      (rd_err),
    .o_mem_write_err     (wr_err),
`endif
    .o_axi_araddr        (araddr),
    .o_axi_arlen         (arlen),
    .o_axi_arvalid       (arvalid),
    .i_axi_arready       (arready),
    .i_axi_rdata         (rdata),
    .i_axi_rresp         (rresp),
    .i_axi_rlast         (rlast),
    .i_axi_rvalid        (rvalid),
    .o_axi_rready        (rready),
    .o_axi_awaddr        (awaddr),
    .o_axi_awvalid       (awvalid),
    .i_axi_awready       (awready),
    .o_axi_wdata         (wdata),
    .o_axi_wstrb         (wstrb),
    .o_axi_wvalid        (wvalid),
    .i_axi_wready        (wready),
    .i_axi_bresp         (bresp),
    .i_axi_bvalid        (bvalid),
    .o_axi_bready        (bready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- slave model configuration ----------------
  int          aw_delay   = 0;
  int          r_gap      = 0;
  int          rlast_beat = BEATS - 1;
  logic [1:0]  cfg_bresp  = RESP_OKAY;
  logic [63:0] beat_data [BEATS];

  // Zero-wait AXI slave with optional AWREADY delay and gaps between R beats.
  initial begin
    bit r_hs, aw_hs, b_hs;
    int rbeat, gapcnt, awcnt;
    rbeat = 0; gapcnt = 0; awcnt = 0;
    arready = 1'b1; wready = 1'b1; awready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = RESP_OKAY; rlast = 1'b0;
    bvalid = 1'b0; bresp = RESP_OKAY;
    forever begin
      @(negedge clk);
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready;
      b_hs  = bvalid && bready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        rvalid = 1'b0; awready = 1'b0; bvalid = 1'b0;
        rbeat = 0; gapcnt = 0; awcnt = 0;
        continue;
      end
      if (!rready) begin
        rvalid = 1'b0; rbeat = 0; gapcnt = 0;
      end else begin
        if (r_hs) begin
          rvalid = 1'b0; rbeat++; gapcnt = r_gap;
        end
        if (!rvalid && rbeat < BEATS) begin
          if (gapcnt > 0) gapcnt--;
          else begin
            rvalid = 1'b1;
            rdata  = beat_data[rbeat];
            rlast  = (rbeat == rlast_beat);
          end
        end
      end
      if (aw_hs || !awvalid) begin
        awready = 1'b0; awcnt = 0;
      end else if (awcnt >= aw_delay) awready = 1'b1;
      else awcnt++;
      if (b_hs) bvalid = 1'b0;
      else if (bready) begin
        bvalid = 1'b1; bresp = cfg_bresp;
      end
    end
  end

  int n_rd_done = 0;
  int n_wr_done = 0;
  always @(negedge clk) begin
    if (rd_done) n_rd_done++;
    if (wr_done) n_wr_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- transaction helper ----------------
  int           t_lat;
  logic         t_v1, t_done_after, t_err;
  logic [63:0]  t_addr1, t_wdata1;
  logic [7:0]   t_strb1, t_len1;
  logic [255:0] t_blk, t_blk_after;

  task automatic run_txn(input bit is_wr, input logic [63:0] addr, input logic [63:0] data,
                         input logic [7:0] strb, input int budget);
    t_lat = -1; t_v1 = 1'b0; t_err = 1'b0; t_addr1 = '0; t_wdata1 = '0;
    t_strb1 = '0; t_len1 = '0; t_blk = '0;
    if (is_wr) begin
      wr_valid = 1'b1; wr_addr = addr; wr_data = data; wr_strb = strb;
    end else begin
      for (int i = 0; i < BEATS; i++) beat_data[i] = data * 64'(i + 1);
      rd_req = 1'b1; rd_addr = addr;
    end
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        t_v1     = is_wr ? (awvalid && wvalid) : arvalid;
        t_addr1  = is_wr ? awaddr : araddr;
        t_wdata1 = wdata;
        t_strb1  = wstrb;
        t_len1   = arlen;
      end
      if (is_wr ? wr_done : rd_done) begin
        t_lat = k;
        t_blk = block;
`ifdef RISCV_DCACHE_AXI_ERR_EN
        t_err = is_wr ? wr_err : rd_err;
`endif
        break;
      end
    end
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    @(posedge clk);
    #1;
    t_done_after = rd_done | wr_done;
    t_blk_after  = block;
  endtask

  typedef struct {
    bit           is_wr;
    logic [63:0]  addr;
    logic [63:0]  data;
    logic [7:0]   strb;
    logic [63:0]  exp_addr;
    logic [255:0] exp_block;
    int           exp_lat;
  } vec_t;

  vec_t vecs [6];
  int   rd0, wr0, first_ar, wr_lat, rd_lat;

  initial begin
    rd_req = 1'b0; wr_valid = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    for (int i = 0; i < BEATS; i++) beat_data[i] = '0;

    // Reads use data as a seed: beat i = seed*(i+1).
    vecs[0] = '{1'b0, 64'h0000_0000_1000_0018, 64'h1111_1111_1111_1111, 8'h00, 64'h0000_0000_1000_0000,
                256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111, 6};
    vecs[1] = '{1'b1, 64'h0000_0000_0000_2004, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h0000_0000_0000_2000, '0, 3};
    vecs[2] = '{1'b0, 64'h0000_0000_8000_003F, 64'h0101_0101_0101_0101, 8'h00, 64'h0000_0000_8000_0020,
                256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101, 6};
    vecs[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFF8, '0, 3};
    vecs[4] = '{1'b1, 64'h0000_0000_0000_100F, 64'h0000_0000_0000_00AA, 8'h01, 64'h0000_0000_0000_1008, '0, 3};
    vecs[5] = '{1'b0, 64'h0000_0000_0000_0020, 64'h1000_0000_0000_0001, 8'h00, 64'h0000_0000_0000_0020,
                256'h4000000000000004_3000000000000003_2000000000000002_1000000000000001, 6};

    #2;
    check("reset_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
    check("reset_dones", {rd_done, wr_done}, 2'b0);
    check("reset_block", block, '0);
    check("reset_addrs", {araddr, awaddr}, '0);
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].is_wr, vecs[v].addr, vecs[v].data, vecs[v].strb, 40);
      check($sformatf("v%0d_latency", v), t_lat, vecs[v].exp_lat);
      check($sformatf("v%0d_valid_c1", v), t_v1, 1'b1);
      check($sformatf("v%0d_addr", v), t_addr1, vecs[v].exp_addr);
      check($sformatf("v%0d_done_1cyc", v), t_done_after, 1'b0);
      if (vecs[v].is_wr) begin
        check($sformatf("v%0d_wstrb", v), t_strb1, vecs[v].strb);
        check($sformatf("v%0d_wdata", v), t_wdata1, vecs[v].data);
      end else begin
        check($sformatf("v%0d_arlen", v), t_len1, 8'd3);
        check($sformatf("v%0d_block", v), t_blk, vecs[v].exp_block);
        check($sformatf("v%0d_block_held", v), t_blk_after, vecs[v].exp_block);
      end
`ifdef RISCV_DCACHE_AXI_ERR_EN
      check($sformatf("v%0d_no_err", v), t_err, 1'b0);
`endif
    end

    // Read and write in the same cycle: write goes first, read only after DONE.
    rd0 = n_rd_done; wr0 = n_wr_done;
    first_ar = -1; wr_lat = -1; rd_lat = -1;
    for (int i = 0; i < BEATS; i++) beat_data[i] = 64'h0A0A_0A0A_0A0A_0A0A * 64'(i + 1);
    wr_valid = 1'b1; wr_addr = 64'h3000; wr_data = 64'h55; wr_strb = 8'h0F;
    rd_req = 1'b1; rd_addr = 64'h4040;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("both_aw_first", {awvalid, wvalid, arvalid}, 3'b110);
      if (arvalid && first_ar < 0) first_ar = k;
      if (wr_done) begin wr_lat = k; wr_valid = 1'b0; end
      if (rd_done) begin rd_lat = k; rd_req = 1'b0; break; end
    end
    @(posedge clk); @(posedge clk);
    #1;
    check("both_wr_latency", wr_lat, 3);
    check("both_first_arvalid", first_ar, 5);
    check("both_rd_latency", rd_lat, 10);
    check("both_block", block, 256'h2828282828282828_1E1E1E1E1E1E1E1E_1414141414141414_0A0A0A0A0A0A0A0A);
    check("both_done_counts", {32'(n_wr_done - wr0), 32'(n_rd_done - rd0)}, {32'd1, 32'd1});

    // Slow slave: AWREADY three cycles after WREADY.
    aw_delay = 3;
    wr0 = n_wr_done; wr_lat = -1;
    wr_valid = 1'b1; wr_addr = 64'h7777; wr_data = 64'hCAFE; wr_strb = 8'h3C;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) check("slow_w_done_aw_held", {wvalid, awvalid}, 2'b01);
      if (k == 3) check("slow_awaddr_stable", {awaddr, wstrb}, {64'h7770, 8'h3C});
      if (wr_done) begin wr_lat = k; wr_valid = 1'b0; break; end
    end
    @(posedge clk); @(posedge clk);
    #1;
    aw_delay = 0;
    check("slow_wr_latency", wr_lat, 6);
    check("slow_wr_done_count", n_wr_done - wr0, 1);

    // Slow slave: two idle cycles between R beats.
    r_gap = 2;
    rd0 = n_rd_done;
    run_txn(1'b0, 64'h9000, 64'h0303_0303_0303_0303, 8'h00, 60);
    r_gap = 0;
    check("gap_rd_latency", t_lat, 12);
    check("gap_block", t_blk, 256'h0C0C0C0C0C0C0C0C_0909090909090909_0606060606060606_0303030303030303);
    check("gap_rd_done_count", n_rd_done - rd0, 1);

    // Reset in the middle of a burst, after two of four beats.
    rd0 = n_rd_done;
    for (int i = 0; i < BEATS; i++) beat_data[i] = 64'h0F0F_0F0F_0F0F_0F0F * 64'(i + 1);
    rd_req = 1'b1; rd_addr = 64'h5000;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_partial", block[127:0], 128'h1E1E1E1E1E1E1E1E_0F0F0F0F0F0F0F0F);
    rst_n = 1'b0;
    rd_req = 1'b0;
    #1;
    check("rst_mid_block", block, '0);
    check("rst_mid_chan", {arvalid, rready, rd_done, araddr}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk);
    #1;
    check("rst_no_done", n_rd_done - rd0, 0);
    run_txn(1'b0, 64'h6008, 64'h1111_1111_1111_1111, 8'h00, 40);
    check("post_rst_latency", t_lat, 6);
    check("post_rst_araddr", t_addr1, 64'h6000);
    check("post_rst_block", t_blk,
          256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

`ifdef RISCV_DCACHE_AXI_ERR_EN
    cfg_bresp = RESP_SLVERR;
    run_txn(1'b1, 64'h2004, 64'h1, 8'h01, 40);
    cfg_bresp = RESP_OKAY;
    check("err_bresp_latency", t_lat, 3);
    check("err_bresp_flag", t_err, 1'b1);
    rlast_beat = 1;
    run_txn(1'b0, 64'h1000, 64'h1111_1111_1111_1111, 8'h00, 40);
    rlast_beat = BEATS - 1;
    check("err_rlast_latency", t_lat, 6);
    check("err_rlast_flag", t_err, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
